// File: rtl/video_pkg.sv
// Shared video types and frame geometry for the camera-to-VGA path.
package video_pkg;

    localparam int LINE_W = 320;
    localparam int LINE_H = 240;
    localparam int OUT_W  = 640;
    localparam int OUT_H  = 480;
    localparam int PIX_W  = 12;
    localparam int ADDR_W = $clog2(LINE_W);

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2,
        READING = 2'd3
    } bank_state_t;

    typedef enum logic {
        WR_IDLE  = 1'b0,
        WR_WRITE = 1'b1
    } wr_state_t;

endpackage

// File: rtl/line_ram.sv
// One camera line of storage: synchronous write, registered read, no reset.
module line_ram
    import video_pkg::*;
#(
    parameter int DEPTH = LINE_W,
    parameter int DW    = PIX_W,
    parameter int AW    = ADDR_W
) (
    input  logic          clk_25mhz,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write port: store one pixel when enabled.
    always_ff @(posedge clk_25mhz) begin
        if (we && (waddr < AW'(DEPTH))) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: one cycle of latency; addresses past the line read as black.
    always_ff @(posedge clk_25mhz) begin
        if (raddr < AW'(DEPTH)) begin
            rdata <= mem[raddr];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/line_doubler_buffer.sv
// Ping-pong line buffer: captures 320-pixel camera lines into two banks and
// replays each stored line twice (two output rows), each pixel twice
// (two output columns), addressed by the VGA scan position.
module line_doubler_buffer
    import video_pkg::*;
(
    input  logic             clk_25mhz,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic             in_sol,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic [9:0]       drawX,
    input  logic [9:0]       drawY,
    output logic [3:0]       pixel_R_out,
    output logic [3:0]       pixel_G_out,
    output logic [3:0]       pixel_B_out,
    output logic             line_ready,
    output logic             underflow,
    output logic             overflow,
    output logic             short_line
);

    // Bank ownership, one registered state per bank.
    bank_state_t bank_q [2];
    bank_state_t bank_d [2];

    // Writer state.
    wr_state_t         wr_state_q, wr_state_d;
    logic              wr_bank_q, wr_bank_d;
    logic [ADDR_W-1:0] wr_x_q, wr_x_d;
    logic              newest_q, newest_d;
    logic              wr_claim, wr_claim_bank, wr_done;
    logic              ovf_set, short_set;
    logic [1:0]        ram_we;
    logic [ADDR_W-1:0] ram_waddr;

    // Reader state.
    logic rd_active_q, rd_active_d;
    logic rd_bank_q, rd_bank_d;
    logic claim_cyc, rd_hit, rd_claim_bank, rd_release, uf_set;

    // Read datapath.
    logic [ADDR_W-1:0] rd_addr_p0;
    logic              rd_en_p0, rd_sel_p0, in_range_p0;
    logic              vld_p1, rd_sel_p1;
    logic [PIX_W-1:0]  rdata0_p1, rdata1_p1;
    rgb444_t           pix_p1;

    // Writer next state: claim an EMPTY bank on start-of-line, fill it, hand it off as FULL.
    always_comb begin
        wr_state_d    = wr_state_q;
        wr_bank_d     = wr_bank_q;
        wr_x_d        = wr_x_q;
        newest_d      = newest_q;
        wr_claim      = 1'b0;
        wr_claim_bank = 1'b0;
        wr_done       = 1'b0;
        ovf_set       = 1'b0;
        short_set     = 1'b0;
        ram_we        = 2'b00;
        ram_waddr     = wr_x_q;
        case (wr_state_q)
            WR_IDLE: begin
                if (in_valid && in_sol) begin
                    if (bank_q[0] == EMPTY || bank_q[1] == EMPTY) begin
                        wr_claim      = 1'b1;
                        wr_claim_bank = (bank_q[0] == EMPTY) ? 1'b0 : 1'b1;
                        wr_bank_d     = wr_claim_bank;
                        ram_we[wr_claim_bank] = 1'b1;
                        ram_waddr     = '0;
                        wr_x_d        = ADDR_W'(1);
                        wr_state_d    = WR_WRITE;
                    end else begin
                        // No free bank: this whole line is lost.
                        ovf_set = 1'b1;
                    end
                end
            end
            WR_WRITE: begin
                if (in_valid) begin
                    ram_we[wr_bank_q] = 1'b1;
                    if (in_sol) begin
                        // Line restarted early: reuse the same bank from x=0.
                        short_set = 1'b1;
                        ram_waddr = '0;
                        wr_x_d    = ADDR_W'(1);
                    end else if (wr_x_q == ADDR_W'(LINE_W - 1)) begin
                        wr_done    = 1'b1;
                        newest_d   = wr_bank_q;
                        wr_x_d     = '0;
                        wr_state_d = WR_IDLE;
                    end else begin
                        wr_x_d = wr_x_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                wr_state_d = WR_IDLE;
            end
        endcase
        if (!reset_n) begin
            ram_we = 2'b00;
        end
    end

    // Reader: claim the oldest FULL bank at the top of each even row, release after the odd row.
    always_comb begin
        rd_active_d   = rd_active_q;
        rd_bank_d     = rd_bank_q;
        rd_hit        = 1'b0;
        rd_claim_bank = 1'b0;
        rd_release    = 1'b0;
        uf_set        = 1'b0;
        claim_cyc     = (drawX == 10'd0) && !drawY[0] && (drawY < 10'(OUT_H));
        if (claim_cyc) begin
            if (bank_q[0] == FULL && bank_q[1] == FULL) begin
                rd_hit        = 1'b1;
                rd_claim_bank = ~newest_q;
            end else if (bank_q[0] == FULL) begin
                rd_hit        = 1'b1;
                rd_claim_bank = 1'b0;
            end else if (bank_q[1] == FULL) begin
                rd_hit        = 1'b1;
                rd_claim_bank = 1'b1;
            end else begin
                uf_set = 1'b1;
            end
            // A pair left open by an irregular scan is dropped here.
            rd_release  = rd_active_q;
            rd_active_d = rd_hit;
            if (rd_hit) begin
                rd_bank_d = rd_claim_bank;
            end
        end else if ((drawX == 10'(OUT_W - 1)) && drawY[0] && rd_active_q) begin
            rd_release  = 1'b1;
            rd_active_d = 1'b0;
        end
        // The claim takes effect for this very cycle's read so column 0 is not lost.
        rd_en_p0    = claim_cyc ? rd_hit : rd_active_q;
        rd_sel_p0   = claim_cyc ? rd_claim_bank : rd_bank_q;
        in_range_p0 = (drawX < 10'(OUT_W)) && (drawY < 10'(OUT_H));
        rd_addr_p0  = drawX[9:1];
    end

    // Bank transitions; writer and reader only ever move disjoint states.
    always_comb begin
        bank_d[0] = bank_q[0];
        bank_d[1] = bank_q[1];
        if (wr_claim) begin
            bank_d[wr_claim_bank] = FILLING;
        end
        if (wr_done) begin
            bank_d[wr_bank_q] = FULL;
        end
        if (rd_release) begin
            bank_d[rd_bank_q] = EMPTY;
        end
        if (rd_hit) begin
            bank_d[rd_claim_bank] = READING;
        end
    end

    // Control state registers.
    always_ff @(posedge clk_25mhz) begin
        if (!reset_n) begin
            bank_q[0]   <= EMPTY;
            bank_q[1]   <= EMPTY;
            wr_state_q  <= WR_IDLE;
            wr_bank_q   <= 1'b0;
            wr_x_q      <= '0;
            newest_q    <= 1'b0;
            rd_active_q <= 1'b0;
            rd_bank_q   <= 1'b0;
        end else begin
            bank_q[0]   <= bank_d[0];
            bank_q[1]   <= bank_d[1];
            wr_state_q  <= wr_state_d;
            wr_bank_q   <= wr_bank_d;
            wr_x_q      <= wr_x_d;
            newest_q    <= newest_d;
            rd_active_q <= rd_active_d;
            rd_bank_q   <= rd_bank_d;
        end
    end

    // Sticky error flags.
    always_ff @(posedge clk_25mhz) begin
        if (!reset_n) begin
            underflow  <= 1'b0;
            overflow   <= 1'b0;
            short_line <= 1'b0;
        end else begin
            underflow  <= underflow  | uf_set;
            overflow   <= overflow   | ovf_set;
            short_line <= short_line | short_set;
        end
    end

    line_ram u_ram0 (
        .clk_25mhz (clk_25mhz),
        .we        (ram_we[0]),
        .waddr     (ram_waddr),
        .wdata     (in_pixel),
        .raddr     (rd_addr_p0),
        .rdata     (rdata0_p1)
    );

    line_ram u_ram1 (
        .clk_25mhz (clk_25mhz),
        .we        (ram_we[1]),
        .waddr     (ram_waddr),
        .wdata     (in_pixel),
        .raddr     (rd_addr_p0),
        .rdata     (rdata1_p1)
    );

    // p0 -> p1: bank select and visibility travel alongside the RAM read.
    always_ff @(posedge clk_25mhz) begin
        if (!reset_n) begin
            vld_p1    <= 1'b0;
            rd_sel_p1 <= 1'b0;
        end else begin
            vld_p1    <= rd_en_p0 && in_range_p0;
            rd_sel_p1 <= rd_sel_p0;
        end
    end

    assign pix_p1      = rd_sel_p1 ? rgb444_t'(rdata1_p1) : rgb444_t'(rdata0_p1);
    assign pixel_R_out = vld_p1 ? pix_p1.r : 4'h0;
    assign pixel_G_out = vld_p1 ? pix_p1.g : 4'h0;
    assign pixel_B_out = vld_p1 ? pix_p1.b : 4'h0;
    assign line_ready  = (bank_q[0] == FULL) || (bank_q[1] == FULL);

endmodule

// File: tb/tb_line_doubler_buffer.sv
// Scoreboard bench for line_doubler_buffer: a driver issues writer beats and
// scan positions and pushes the expected registered outputs; a monitor pops
// and compares one entry per clock.
`timescale 1ns/1ps
module tb_line_doubler_buffer;

    logic        clk_25mhz = 1'b0;
    logic        reset_n   = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_sol    = 1'b0;
    logic [11:0] in_pixel  = 12'h0;
    logic [9:0]  drawX     = 10'd700;
    logic [9:0]  drawY     = 10'd500;
    logic [3:0]  pixel_R_out, pixel_G_out, pixel_B_out;
    logic        line_ready, underflow, overflow, short_line;

    always #20 clk_25mhz = ~clk_25mhz;

    line_doubler_buffer dut (
        .clk_25mhz   (clk_25mhz),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_sol      (in_sol),
        .in_pixel    (in_pixel),
        .drawX       (drawX),
        .drawY       (drawY),
        .pixel_R_out (pixel_R_out),
        .pixel_G_out (pixel_G_out),
        .pixel_B_out (pixel_B_out),
        .line_ready  (line_ready),
        .underflow   (underflow),
        .overflow    (overflow),
        .short_line  (short_line)
    );

    typedef struct {
        logic        v;
        logic        s;
        logic [11:0] px;
    } wr_beat_t;

    wr_beat_t    wq[$];
    logic [15:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    // Reference model: line store per bank, FIFO of completed lines (oldest first),
    // the bank being shown (-1 none) and the bank being filled (-1 none).
    logic [11:0] mdata [2][320];
    int          mfull[$];
    int          mread = -1;
    int          mfill = -1;
    int          mwp   = 0;
    bit          muf = 0, movf = 0, mshort = 0;

    function automatic bit in_full(input int b);
        foreach (mfull[i]) if (mfull[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [15:0] model_step(input logic rn, input logic v, input logic s,
                                               input logic [11:0] px, input int x, input int y);
        bit          emp [2];
        bit          claim;
        int          rb;
        int          nb;
        logic [11:0] pix;
        if (!rn) begin
            mfull.delete();
            mread  = -1;
            mfill  = -1;
            mwp    = 0;
            muf    = 0;
            movf   = 0;
            mshort = 0;
            return 16'h0000;
        end
        for (int b = 0; b < 2; b++) emp[b] = (b != mread) && (b != mfill) && !in_full(b);
        claim = (x == 0) && (y % 2 == 0) && (y < 480);
        rb = mread;
        if (claim) rb = (mfull.size() > 0) ? mfull[0] : -1;
        pix = 12'h000;
        if (x < 640 && y < 480 && rb >= 0) pix = mdata[rb][x / 2];
        // reader, decided on the state before this edge
        if (claim) begin
            if (mfull.size() > 0) mread = mfull.pop_front();
            else begin
                mread = -1;
                muf   = 1;
            end
        end else if (x == 639 && (y % 2 == 1) && mread >= 0) begin
            mread = -1;
        end
        // writer, also on the state before this edge
        if (mfill < 0) begin
            if (v && s) begin
                nb = emp[0] ? 0 : (emp[1] ? 1 : -1);
                if (nb < 0) movf = 1;
                else begin
                    mfill        = nb;
                    mdata[nb][0] = px;
                    mwp          = 1;
                end
            end
        end else if (v) begin
            if (s) begin
                mshort          = 1;
                mdata[mfill][0] = px;
                mwp             = 1;
            end else begin
                mdata[mfill][mwp] = px;
                mwp++;
                if (mwp == 320) begin
                    mfull.push_back(mfill);
                    mfill = -1;
                end
            end
        end
        return {(mfull.size() > 0), muf, movf, mshort, pix};
    endfunction

    function automatic logic [11:0] basic_px(input int i);
        logic [8:0] xi;
        xi = 9'(i);
        return {xi[3:0], ~xi[3:0], 4'h5};
    endfunction

    // One clock of stimulus; a writer beat is consumed only outside reset.
    task automatic cyc(input logic rn, input int x, input int y);
        wr_beat_t b;
        b = '{v: 1'b0, s: 1'b0, px: 12'h000};
        if (rn && wq.size() > 0) b = wq.pop_front();
        @(negedge clk_25mhz);
        reset_n  = rn;
        in_valid = b.v;
        in_sol   = b.s;
        in_pixel = b.px;
        drawX    = 10'(x);
        drawY    = 10'(y);
        exp_q.push_back(model_step(rn, b.v, b.s, b.px, x, y));
    endtask

    task automatic push_line(input int n, input bit pat, input int gap_pct);
        wr_beat_t b;
        for (int i = 0; i < n; i++) begin
            while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                b = '{v: 1'b0, s: 1'($urandom_range(1)), px: 12'($urandom)};
                wq.push_back(b);
            end
            b = '{v: 1'b1, s: (i == 0), px: (pat ? basic_px(i) : 12'($urandom))};
            wq.push_back(b);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 700, 500);
    endtask

    task automatic drain();
        while (wq.size() > 0) cyc(1'b1, 700, 500);
    endtask

    task automatic do_reset(input int n);
        wq.delete();
        for (int i = 0; i < n; i++) cyc(1'b0, 700, 500);
    endtask

    task automatic scan(input int y0, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = 0; x < 660; x++) cyc(1'b1, x, y);
    endtask

    logic [15:0] mon_exp, mon_act;

    // Monitor: compare the outputs registered at each edge against the scoreboard.
    always @(posedge clk_25mhz) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {line_ready, underflow, overflow, short_line,
                       pixel_R_out, pixel_G_out, pixel_B_out};
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL out t=%0t drawX=%0d drawY=%0d {rdy,uf,ovf,short,rgb} got %h expected %h",
                         $time, drawX, drawY, mon_act, mon_exp);
            end
        end
    end

    initial begin
        // Reset state, then reset in the middle of a line.
        do_reset(3);
        push_line(320, 1'b1, 0);
        idle(100);
        do_reset(2);
        // Basic replay of the pattern line into bank 0, then the bank must be free again.
        push_line(320, 1'b1, 25);
        drain();
        idle(2);
        scan(0, 3);

        // Underflow on an empty buffer, then a late line shows on rows 2-3.
        do_reset(2);
        scan(0, 1);
        push_line(320, 1'b0, 30);
        drain();
        scan(2, 3);

        // Overflow: three lines with the reader idle.
        do_reset(2);
        for (int i = 0; i < 3; i++) push_line(320, 1'b0, 20);
        drain();
        idle(5);
        scan(0, 3);

        // Short line followed by a complete line into the same bank.
        do_reset(2);
        push_line(100, 1'b0, 10);
        push_line(320, 1'b0, 10);
        drain();
        scan(0, 1);

        // Writer completes exactly on the row-0 claim cycle.
        do_reset(2);
        push_line(320, 1'b1, 0);
        idle(319);
        scan(0, 3);

        // Random concurrent traffic with occasional short lines.
        do_reset(2);
        for (int i = 0; i < 7; i++) begin
            if ($urandom_range(3) == 0) push_line(int'($urandom_range(1, 200)), 1'b0, 40);
            push_line(320, 1'b0, int'($urandom_range(40, 70)));
        end
        scan(0, 11);
        drain();
        idle(4);

        repeat (3) @(posedge clk_25mhz);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_doubler_buffer.md
Name: line_doubler_buffer

Overview:
- Ping-pong line buffer directly upstream of the 2x upscale stage.
- Accepts 320-pixel RGB444 camera lines, already synchronised into the pixel clock domain with a valid strobe.
- Replays each stored pixel twice horizontally and each stored line twice vertically, indexed by the VGA controller's drawX/drawY.
- Produces the pixel_R/G/B stream the upscale stage consumes.

Parameters:
- LINE_W, 320: input pixels per line.
- LINE_H, 240: input lines per frame.
- OUT_W, 640: visible output width (must equal 2*LINE_W).
- OUT_H, 480: visible output height (must equal 2*LINE_H).
- PIX_W, 12: packed RGB444 pixel width.

Ports:
- clk_25mhz  in  1  VGA pixel clock; the only clock.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  in_pixel is valid this cycle.
- in_sol  in  1  start of line; qualified by in_valid, marks pixel x=0.
- in_pixel  in  12  {R[11:8],G[7:4],B[3:0]}.
- drawX  in  10  current output column.
- drawY  in  10  current output row.
- pixel_R_out  out  4  red to upscale stage.
- pixel_G_out  out  4  green.
- pixel_B_out  out  4  blue.
- line_ready  out  1  at least one bank is FULL.
- underflow  out  1  sticky: reader found no FULL bank.
- overflow  out  1  sticky: writer found no EMPTY bank; line dropped.
- short_line  out  1  sticky: in_sol arrived before 320 pixels were written.

Behaviour:
- Interface: one clock, clk_25mhz. reset_n is synchronous and active-low. All state changes on posedge clk_25mhz only.
- Reset:
  - All pixel outputs, line_ready and all flags go to 0.
  - Both banks go to EMPTY; writer goes to IDLE; reader holds no bank.
  - RAM contents are not cleared.
  - Reset asserted mid-line discards the partial line and any FULL/READING bank.
- Bank state, per bank, 2 bits: EMPTY -> FILLING -> FULL -> READING -> EMPTY. A bank is held in exactly one state.
- Writer FSM, IDLE/WRITE:
  - IDLE: in_valid&in_sol claims the lowest-index EMPTY bank (-> FILLING), writes the pixel at x=0, sets wr_x=1, goes to WRITE.
  - IDLE with no EMPTY bank: set overflow; ignore pixels until the next in_sol.
  - WRITE: each in_valid writes at wr_x and increments it. A write at wr_x=LINE_W-1 sets the bank to FULL, records it as newest_full, and returns to IDLE.
  - WRITE with in_valid&in_sol: set short_line; restart the same bank at x=0 with that pixel.
  - in_valid without in_sol in IDLE: ignored.
- Reader:
  - Claim: at drawX==0 with drawY even and drawY<OUT_H, claim the oldest FULL bank (-> READING).
  - Age order: with both banks FULL, the one not equal to newest_full is oldest.
  - Miss: if no bank is FULL at claim time, set underflow; output black for both output rows of that pair.
  - Release: at drawX==OUT_W-1 with drawY odd, the READING bank -> EMPTY.
- Simultaneous events:
  - Bank state is registered, so a transition made in cycle N is visible to the other side from cycle N+1.
  - A writer completing a line on the reader's claim cycle does not satisfy that claim.
  - A bank released on the writer's in_sol cycle is not claimable by the writer that cycle; that line drops and sets overflow.
- Read datapath:
  - Address is drawX>>1 (9 bits), read synchronously from the READING bank.
  - Outputs are registered with exactly 1 cycle of latency relative to drawX/drawY.
  - Outputs are 0 when the previous cycle's drawX>=OUT_W, drawY>=OUT_H, or no bank was READING.
- Flags: underflow, overflow and short_line are set-only until reset.
- line_ready is combinational from the registered bank states.

Decomposition:
- Shared package video_pkg holds:
  - rgb444_t, a packed struct of 4-bit r, g and b fields.
  - bank_state_t enum (EMPTY, FILLING, FULL, READING).
  - Constants LINE_W, LINE_H, OUT_W, OUT_H.
- One sub-module, line_ram: LINE_W x PIX_W simple dual-port memory with a sync write port, a 1-cycle sync read port and no reset. It is instantiated twice.

Test Plan:
- Reset dominance: reset_n=0 for 2 cycles mid-line, then 1.
  - All outputs and flags read 0; both banks EMPTY.
  - The next in_sol line fills bank 0.
- Basic replay: write line with pixel x = {x[3:0],~x[3:0],4'h5}, then scan drawY=0,1 and drawX=0..639.
  - Output at cycle after drawX=2k equals pixel k, e.g. drawX=7 -> 12'h3C5.
  - Rows 0 and 1 are identical.
  - Bank EMPTY after drawX=639 on drawY=1.
- Underflow: no input lines, scan drawY=0.
  - underflow=1, all outputs 0 for rows 0-1.
  - A line loaded before drawY=2 is shown on rows 2-3.
- Overflow: write three complete lines with no reader activity.
  - The first two become FULL and line_ready=1.
  - The third is dropped and overflow=1; bank contents equal lines 1 and 2.
- Short line: in_sol, 100 pixels, then in_sol.
  - short_line=1; the same bank restarts at x=0.
  - It becomes FULL only after 320 further pixels.
- Simultaneous edge: the writer's x=319 write lands exactly on the drawX==0, drawY=0 claim cycle with no other bank FULL.
  - underflow=1 and rows 0-1 are black.
  - The bank stays FULL and is claimed at drawY=2.
